// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: instruction fetch vs data load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; otherwise data wins conflicts.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [BE_WIDTH-1:0]   d_byte_enable,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [BE_WIDTH-1:0]   mem_byte_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SERVE_I = 2'b01,
      SERVE_D = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic                  i_req_s, d_req_s, grant_i_s, grant_d_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // prio_q = 1 means the data side wins the next conflict
   logic                  prio_q, prio_d;
`endif

   always_comb begin
      i_req_s = i_read;
      d_req_s = d_read | d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (i_req_s && d_req_s) begin
         grant_d_s = prio_q;
         grant_i_s = ~prio_q;
      end else begin
         grant_d_s = d_req_s;
         grant_i_s = i_req_s;
      end
`else
      grant_d_s = d_req_s;
      grant_i_s = i_req_s & ~d_req_s;
`endif
   end

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_d      = prio_q;
`endif
      case (state_q)
         IDLE: begin
            // both read and write high is treated as a write
            if (grant_d_s) begin
               state_d     = SERVE_D;
               mem_read_d  = ~d_write;
               mem_write_d = d_write;
               addr_d      = d_address;
               wdata_d     = d_wdata;
               be_d        = d_byte_enable;
            end else if (grant_i_s) begin
               state_d     = SERVE_I;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               addr_d      = i_address;
               wdata_d     = {DATA_WIDTH{1'b0}};
               be_d        = {BE_WIDTH{1'b1}};
            end else begin
               state_d     = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               prio_d      = (state_q == SERVE_I);
`endif
            end else begin
               state_d     = state_q;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         be_q        <= {BE_WIDTH{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
         prio_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         prio_q      <= prio_d;
`endif
      end
   end

   // responses follow mem_resp in the same cycle, only to the owner
   assign i_resp          = mem_resp & (state_q == SERVE_I);
   assign d_resp          = mem_resp & (state_q == SERVE_D);
   assign i_rdata         = mem_rdata;
   assign d_rdata         = mem_rdata;
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request patterns
// checked against a transaction-order model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        i_read, d_read, d_write, mem_resp;
   logic [31:0] i_address, d_address, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
   logic [3:0]  d_byte_enable, mem_byte_enable;
   logic        i_resp, d_resp, mem_read, mem_write;

   int errors = 0;
   int checks = 0;
   bit prio_m;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
      .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one granted transaction as seen from the memory side, answered after lat cycles
   task automatic serve(input bit sd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit wr, input int lat,
                        input logic [31:0] rd, input bit chg, input logic [31:0] chg_addr);
      int n;
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("grant_latency", 64'(n), 64'(1));
      chk("mem_read", 64'(mem_read), 64'(!wr));
      chk("mem_write", 64'(mem_write), 64'(wr));
      chk("mem_address", 64'(mem_address), 64'(addr));
      chk("mem_byte_enable", 64'(mem_byte_enable), 64'(be));
      if (wr) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
      for (int k = 0; k < lat; k++) begin
         if (chg && k == 0) d_address = chg_addr;
         @(negedge clk);
         chk("addr_stable", 64'(mem_address), 64'(addr));
         chk("no_early_resp", 64'({i_resp, d_resp}), 64'(0));
      end
      mem_rdata = rd;
      mem_resp  = 1'b1;
      #1;
      chk("i_resp", 64'(i_resp), 64'(!sd));
      chk("d_resp", 64'(d_resp), 64'(sd));
      chk("rdata", 64'(sd ? d_rdata : i_rdata), 64'(rd));
      @(posedge clk);
      #1;
      mem_resp  = 1'b0;
      mem_rdata = $urandom;
      if (sd) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      @(negedge clk);
      chk("dead_cycle", 64'({mem_read, mem_write, i_resp, d_resp}), 64'(0));
   endtask

   // drive a request pattern; the expected service order comes from the priority model
   task automatic run_pattern(input bit ion, input bit don, input int dop, input int lat);
      logic [31:0] ia, da, dw;
      logic [3:0]  db;
      bit          dwr, first_d, sd;
      ia = $urandom; da = $urandom; dw = $urandom;
      db = 4'($urandom_range(0, 15));
      dwr = (dop != 0);
      i_read = ion; i_address = ia;
      d_read = don && (dop != 1); d_write = don && (dop != 0);
      d_address = da; d_wdata = dw; d_byte_enable = db;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first_d = (ion && don) ? prio_m : don;
`else
      first_d = don;
`endif
      for (int s = 0; s < 2; s++) begin
         sd = (s == 0) ? first_d : !first_d;
         if (sd && don) serve(1'b1, da, dw, db, dwr, lat, $urandom, 1'b0, 32'h0);
         if (!sd && ion) serve(1'b0, ia, 32'h0, 4'hF, 1'b0, lat, $urandom, 1'b0, 32'h0);
         if ((sd && don) || (!sd && ion)) prio_m = !sd;
      end
   endtask

   initial begin
      prio_m = 1'b1;
      rst = 1'b1; i_read = 1'b1; i_address = 32'h0000_0060;
      d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_wdata = 32'h0;
      d_byte_enable = 4'h0; mem_resp = 1'b0; mem_rdata = 32'h0;

      // reset held two cycles with a fetch pending
      repeat (2) begin
         @(negedge clk);
         chk("rst_strobes", 64'({mem_read, mem_write}), 64'(0));
         chk("rst_i_resp", 64'(i_resp), 64'(0));
         chk("rst_address", 64'(mem_address), 64'(0));
      end
      rst = 1'b0;

      // single fetch after reset
      serve(1'b0, 32'h0000_0060, 32'h0, 4'hF, 1'b0, 3, 32'h00A0_0093, 1'b0, 32'h0);
      prio_m = 1'b1;

      // data write with partial mask
      d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
      serve(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 2, 32'h1234_5678, 1'b0, 32'h0);
      prio_m = 1'b0;

      // simultaneous conflict
      run_pattern(1'b1, 1'b1, 0, 2);

      // address change while being served
      d_read = 1'b1; d_address = 32'h0000_2000; d_byte_enable = 4'hF;
      serve(1'b1, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 3, 32'hCAFE_F00D, 1'b1, 32'h0000_3000);
      prio_m = 1'b0;

      // stray mem_resp in IDLE
      mem_resp = 1'b1;
      #1;
      chk("stray_resp", 64'({i_resp, d_resp}), 64'(0));
      @(negedge clk);
      mem_resp = 1'b0;
      chk("stray_strobes", 64'({mem_read, mem_write}), 64'(0));

      // illegal read+write becomes a write
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0044; d_wdata = 32'h0BAD_F00D; d_byte_enable = 4'b1100;
      serve(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'b1100, 1'b1, 1, 32'h0, 1'b0, 32'h0);
      prio_m = 1'b0;

      // four back-to-back conflicts
      for (int r = 0; r < 4; r++) run_pattern(1'b1, 1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

      // reset in the middle of a transaction, then a late response
      d_read = 1'b1; d_address = $urandom;
      @(negedge clk);
      chk("mid_strobe", 64'(mem_read), 64'(1));
      rst = 1'b1; d_read = 1'b0;
      @(negedge clk);
      chk("mid_rst_strobes", 64'({mem_read, mem_write}), 64'(0));
      rst = 1'b0; mem_resp = 1'b1;
      #1;
      chk("late_resp", 64'({i_resp, d_resp}), 64'(0));
      @(negedge clk);
      mem_resp = 1'b0;
      chk("late_strobes", 64'({mem_read, mem_write}), 64'(0));
      prio_m = 1'b1;

      // randomized request patterns
      for (int r = 0; r < 16; r++) begin
         int k;
         k = int'($urandom_range(1, 3));
         run_pattern(k[0], k[1], int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
